// File: rtl/sh2_bus_arbiter_pkg.sv
// Shared definitions for the dual SH-2 external bus arbiter:
// arbiter state encoding, owner encoding and an owner decode helper.
package sh2_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_M = 2'd1,
    OWN_S = 2'd2,
    GAP   = 2'd3
  } ArbState_t;

  localparam logic [1:0] ARB_NONE = 2'b00;
  localparam logic [1:0] ARB_M    = 2'b01;
  localparam logic [1:0] ARB_S    = 2'b10;

  // Map an arbiter state onto the externally visible owner code.
  function automatic logic [1:0] owner_of(input ArbState_t st);
    logic [1:0] own;
    case (st)
      OWN_M:   own = ARB_M;
      OWN_S:   own = ARB_S;
      default: own = ARB_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/sh2_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared SH-2 external bus.
// Locked (TAS) sequences hold the bus, every hand-over inserts a
// TURN_CYC-cycle turnaround gap, and all outputs are registered.
// Optional feature macro: SH_ARB_TENURE_EN -- compiles in a tenure
// counter that preempts an unlocked owner at its MAX_TEN-th END while
// the other requester waits.
module sh2_bus_arbiter
  import sh2_bus_arbiter_pkg::*;
#(
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_TEN  = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE_R,
  input  logic       M_REQ,
  input  logic       M_LOCK,
  input  logic       M_END,
  output logic       M_GNT,
  input  logic       S_REQ,
  input  logic       S_LOCK,
  input  logic       S_END,
  output logic       S_GNT,
  output logic [1:0] OWNER,
  output logic       TURN
);

  // Gap counter value on which the gap ends (counts 0..TURN_CYC-1).
  localparam logic [2:0] GAP_LAST = 3'(TURN_CYC - 1);

  ArbState_t  r_state;
  ArbState_t  w_state_nxt;
  logic       r_last_s;      // 1: slave was the last owner, 0: master
  logic       w_last_s_nxt;
  logic [2:0] r_gap_cnt;
  logic [2:0] w_gap_cnt_nxt;
  logic       r_m_gnt;
  logic       r_s_gnt;
  logic [1:0] r_owner;
  logic       r_turn;
  logic       w_preempt_m;
  logic       w_preempt_s;
  logic       w_rel_m;
  logic       w_rel_s;

`ifdef SH_ARB_TENURE_EN
  localparam logic [8:0] TEN_LIM = 9'(MAX_TEN);

  logic [7:0] r_ten_cnt;
  logic [7:0] w_ten_cnt_nxt;
  logic [8:0] w_ten_inc;

  // The END being evaluated counts toward the tenure, so compare count+1.
  assign w_ten_inc   = {1'b0, r_ten_cnt} + 9'd1;
  assign w_preempt_m = M_END && S_REQ && (w_ten_inc >= TEN_LIM);
  assign w_preempt_s = S_END && M_REQ && (w_ten_inc >= TEN_LIM);
`else
  // Without tenure limiting the END strobes and MAX_TEN have no effect.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{M_END, S_END, 8'(MAX_TEN)};
  assign w_preempt_m  = 1'b0;
  assign w_preempt_s  = 1'b0;
`endif

  // Release priority: dropped REQ always releases, LOCK holds, then preemption.
  assign w_rel_m = !M_REQ || (!M_LOCK && w_preempt_m);
  assign w_rel_s = !S_REQ || (!S_LOCK && w_preempt_s);

  // Next-state, last-owner and counter logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_s_nxt  = r_last_s;
    w_gap_cnt_nxt = r_gap_cnt;
`ifdef SH_ARB_TENURE_EN
    w_ten_cnt_nxt = r_ten_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (M_REQ && S_REQ) begin
          w_state_nxt = r_last_s ? OWN_M : OWN_S;
        end else if (M_REQ) begin
          w_state_nxt = OWN_M;
        end else if (S_REQ) begin
          w_state_nxt = OWN_S;
        end else begin
          w_state_nxt = IDLE;
        end
`ifdef SH_ARB_TENURE_EN
        w_ten_cnt_nxt = 8'd0;
`endif
      end
      OWN_M: begin
        if (w_rel_m) begin
          w_state_nxt   = GAP;
          w_last_s_nxt  = 1'b0;
          w_gap_cnt_nxt = 3'd0;
        end else begin
          w_state_nxt = OWN_M;
`ifdef SH_ARB_TENURE_EN
          if (M_END && (r_ten_cnt != 8'hFF)) begin
            w_ten_cnt_nxt = r_ten_cnt + 8'd1;
          end else begin
            w_ten_cnt_nxt = r_ten_cnt;
          end
`endif
        end
      end
      OWN_S: begin
        if (w_rel_s) begin
          w_state_nxt   = GAP;
          w_last_s_nxt  = 1'b1;
          w_gap_cnt_nxt = 3'd0;
        end else begin
          w_state_nxt = OWN_S;
`ifdef SH_ARB_TENURE_EN
          if (S_END && (r_ten_cnt != 8'hFF)) begin
            w_ten_cnt_nxt = r_ten_cnt + 8'd1;
          end else begin
            w_ten_cnt_nxt = r_ten_cnt;
          end
`endif
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          // The other requester has priority; the previous owner may re-take.
          if (r_last_s ? M_REQ : S_REQ) begin
            w_state_nxt = r_last_s ? OWN_M : OWN_S;
          end else if (r_last_s ? S_REQ : M_REQ) begin
            w_state_nxt = r_last_s ? OWN_S : OWN_M;
          end else begin
            w_state_nxt = IDLE;
          end
`ifdef SH_ARB_TENURE_EN
          w_ten_cnt_nxt = 8'd0;
`endif
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset wins over CE_R.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= IDLE;
      r_last_s  <= 1'b1;
      r_gap_cnt <= 3'd0;
      r_m_gnt   <= 1'b0;
      r_s_gnt   <= 1'b0;
      r_owner   <= ARB_NONE;
      r_turn    <= 1'b0;
`ifdef SH_ARB_TENURE_EN
      r_ten_cnt <= 8'd0;
`endif
    end else if (CE_R) begin
      r_state   <= w_state_nxt;
      r_last_s  <= w_last_s_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_m_gnt   <= (w_state_nxt == OWN_M);
      r_s_gnt   <= (w_state_nxt == OWN_S);
      r_owner   <= owner_of(w_state_nxt);
      r_turn    <= (w_state_nxt == GAP);
`ifdef SH_ARB_TENURE_EN
      r_ten_cnt <= w_ten_cnt_nxt;
`endif
    end
  end

  assign M_GNT = r_m_gnt;
  assign S_GNT = r_s_gnt;
  assign OWNER = r_owner;
  assign TURN  = r_turn;

endmodule

// File: tb/tb_sh2_bus_arbiter.sv
// Directed self-checking bench for sh2_bus_arbiter (TURN_CYC=2, MAX_TEN=4).
// Expected output vectors {M_GNT,S_GNT,OWNER,TURN} are queued as each cycle
// is driven and popped/compared one edge later. Expectations that depend on
// SH_ARB_TENURE_EN follow the same macro.
module tb_sh2_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N, CE_R;
  logic       M_REQ, M_LOCK, M_END, S_REQ, S_LOCK, S_END;
  logic       M_GNT, S_GNT, TURN;
  logic [1:0] OWNER;
  logic [4:0] obs;

  localparam logic [4:0] IDLE0 = 5'b00_00_0;
  localparam logic [4:0] MOWN  = 5'b10_01_0;
  localparam logic [4:0] SOWN  = 5'b01_10_0;
  localparam logic [4:0] GAPV  = 5'b00_00_1;

  typedef struct {
    logic [4:0] exp;
    string      tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  sh2_bus_arbiter #(.TURN_CYC(2), .MAX_TEN(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
    .M_REQ(M_REQ), .M_LOCK(M_LOCK), .M_END(M_END), .M_GNT(M_GNT),
    .S_REQ(S_REQ), .S_LOCK(S_LOCK), .S_END(S_END), .S_GNT(S_GNT),
    .OWNER(OWNER), .TURN(TURN)
  );

  always #5 CLK = ~CLK;

  assign obs = {M_GNT, S_GNT, OWNER, TURN};

  // Queue the expectation, advance one edge, then pop and compare.
  task automatic cyc(input logic [4:0] exp, input string tag);
    sb_t e;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    RST_N = 1'b0; CE_R = 1'b1;
    M_REQ = 1'b0; M_LOCK = 1'b0; M_END = 1'b0;
    S_REQ = 1'b0; S_LOCK = 1'b0; S_END = 1'b0;

    // Reset state
    cyc(IDLE0, "reset_a");
    cyc(IDLE0, "reset_b");
    RST_N = 1'b1;
    cyc(IDLE0, "idle_no_req");

    // Single master request, release and gap back to idle
    M_REQ = 1'b1;
    cyc(MOWN, "m_grant");
    cyc(MOWN, "m_hold");
    M_REQ = 1'b0;
    cyc(GAPV, "m_release");
    cyc(GAPV, "m_gap_2");
    cyc(IDLE0, "idle_after_gap");

    // Fresh reset, simultaneous requests: master wins, then hand-over to slave
    RST_N = 1'b0;
    cyc(IDLE0, "reset_again");
    RST_N = 1'b1;
    M_REQ = 1'b1; S_REQ = 1'b1;
    cyc(MOWN, "tie_master_first");
    M_REQ = 1'b0;
    cyc(GAPV, "tie_gap_1");
    cyc(GAPV, "tie_gap_2");
    cyc(SOWN, "tie_slave_next");

    // END strobe from the non-owner is ignored
    M_END = 1'b1;
    cyc(SOWN, "stray_end");
    M_END = 1'b0;
    cyc(SOWN, "stray_end_after");

    // Locked slave holds through many ENDs while master waits
    S_LOCK = 1'b1; M_REQ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      S_END = 1'b1;
      cyc(SOWN, "lock_end");
      S_END = 1'b0;
      cyc(SOWN, "lock_hold");
    end
    S_LOCK = 1'b0; S_END = 1'b1;
`ifdef SH_ARB_TENURE_EN
    cyc(GAPV, "lock_drop_preempt");
    S_END = 1'b0;
    cyc(GAPV, "lock_drop_gap");
    cyc(MOWN, "lock_drop_m_grant");
`else
    cyc(SOWN, "lock_drop_no_preempt");
    S_END = 1'b0;
    S_REQ = 1'b0;
    cyc(GAPV, "s_release");
    cyc(GAPV, "s_release_gap");
    cyc(MOWN, "s_release_m_grant");
    S_REQ = 1'b1;
`endif

    // Continuous contention: tenure alternation or indefinite master hold
    for (int r = 0; r < 2; r++) begin
      for (int e = 1; e <= 4; e++) begin
`ifdef SH_ARB_TENURE_EN
        if (r == 0) M_END = 1'b1; else S_END = 1'b1;
        cyc((e < 4) ? ((r == 0) ? MOWN : SOWN) : GAPV, "tenure_end");
        M_END = 1'b0; S_END = 1'b0;
        if (e < 4) begin
          cyc((r == 0) ? MOWN : SOWN, "tenure_hold");
        end else begin
          cyc(GAPV, "tenure_gap");
          cyc((r == 0) ? SOWN : MOWN, "tenure_handover");
        end
`else
        M_END = 1'b1;
        cyc(MOWN, "no_tenure_end");
        M_END = 1'b0;
        cyc(MOWN, "no_tenure_hold");
`endif
      end
    end

    // Release into gap, freeze with CE_R low, then resume the gap
    M_REQ = 1'b0;
    cyc(GAPV, "freeze_release");
    CE_R = 1'b0;
    for (int i = 0; i < 10; i++) cyc(GAPV, "freeze_gap");
    CE_R = 1'b1;
    cyc(GAPV, "resume_gap");
    cyc(SOWN, "resume_s_grant");

    // Reset while slave owns and CE_R is low
    CE_R = 1'b0; RST_N = 1'b0;
    cyc(IDLE0, "reset_ce_low");
    RST_N = 1'b1; CE_R = 1'b1; M_REQ = 1'b1;
    cyc(MOWN, "tie_after_reset");

    // REQ drop with END, previous owner re-takes the bus after the gap
    S_REQ = 1'b0; M_REQ = 1'b0; M_END = 1'b1;
    cyc(GAPV, "req_drop_with_end");
    M_END = 1'b0; M_REQ = 1'b1;
    cyc(GAPV, "regrant_gap");
    cyc(MOWN, "regrant_same");
    M_REQ = 1'b0;
    cyc(GAPV, "final_release");
    cyc(GAPV, "final_gap");
    cyc(IDLE0, "final_idle");
    S_REQ = 1'b1;
    cyc(SOWN, "s_alone_grant");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
